// File: rtl/decode_wave_sched.sv
// Round-robin wavefront scheduler feeding instruction words to decode; holds the
// grant across both halves of a 64-bit instruction so halves never interleave.
module decode_wave_sched #(
  parameter int NUM_WF = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] ibuf_ready,
  input  logic [NUM_WF-1:0] wf_blocked,
  input  logic              wave_ins_half_rqd,
  input  logic [5:0]        wave_ins_half_wfid,
  output logic              ibuf_rd_en,
  output logic [5:0]        ibuf_rd_wfid,
  output logic              wave_instr_valid,
  output logic [5:0]        wave_wfid,
  output logic              sched_half_pending,
  output logic              sched_err
);

  typedef enum logic [1:0] {IDLE, READ, CHECK, HALF} state_t;

  localparam logic [5:0] LAST_WF = 6'(NUM_WF - 1);

  state_t            state, state_nxt;
  logic [5:0]        cur_wfid, cur_wfid_nxt;
  logic [5:0]        rr_ptr, rr_ptr_nxt;
  logic              err_nxt;
  logic              take_grant;
  logic [NUM_WF-1:0] elig;
  logic [5:0]        winner;
  logic              found;
  logic [6:0]        idx;

  assign elig = ibuf_ready & ~wf_blocked;

  // First eligible slot at or above rr_ptr, wrapping at NUM_WF.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      idx = {1'b0, rr_ptr} + 7'(i);
      if (idx >= 7'(NUM_WF)) idx = idx - 7'(NUM_WF);
      if (!found && elig[idx[5:0]]) begin
        winner = idx[5:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cur_wfid_nxt = cur_wfid;
    rr_ptr_nxt   = rr_ptr;
    err_nxt      = sched_err;
    take_grant   = 1'b0;
    case (state)
      IDLE:  take_grant = 1'b1;
      READ:  state_nxt = CHECK;
      CHECK: begin
        if (wave_ins_half_rqd && (wave_ins_half_wfid == cur_wfid)) begin
          state_nxt = HALF;
        end else begin
          // A half request for some other wavefront is flagged and then ignored.
          if (wave_ins_half_rqd) err_nxt = 1'b1;
          take_grant = 1'b1;
        end
      end
      HALF:  if (ibuf_ready[cur_wfid]) state_nxt = READ;
      default: state_nxt = IDLE;
    endcase
    if (take_grant) begin
      if (found) begin
        state_nxt    = READ;
        cur_wfid_nxt = winner;
        rr_ptr_nxt   = (winner == LAST_WF) ? 6'd0 : winner + 6'd1;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Outputs are registered from the next state so they line up with READ/CHECK/HALF.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cur_wfid           <= '0;
      rr_ptr             <= '0;
      ibuf_rd_en         <= 1'b0;
      ibuf_rd_wfid       <= '0;
      wave_instr_valid   <= 1'b0;
      wave_wfid          <= '0;
      sched_half_pending <= 1'b0;
      sched_err          <= 1'b0;
    end else begin
      state              <= state_nxt;
      cur_wfid           <= cur_wfid_nxt;
      rr_ptr             <= rr_ptr_nxt;
      ibuf_rd_en         <= (state_nxt == READ);
      ibuf_rd_wfid       <= (state_nxt == READ) ? cur_wfid_nxt : 6'd0;
      wave_instr_valid   <= (state_nxt == CHECK);
      wave_wfid          <= (state_nxt == CHECK) ? cur_wfid_nxt : 6'd0;
      sched_half_pending <= (state_nxt == HALF);
      sched_err          <= err_nxt;
    end
  end

endmodule
